// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - time-of-day counter with RUN/SET_HOUR/SET_MIN button control and set-mode blink
// Optional 12-hour build with pm flag: define CLOCK_CTRL_HOUR12_EN.
module clock_ctrl #(
    parameter int BLINK_DIV = 50000000
) (
    input  logic       clk_100M,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] mode,
    output logic       blink,
    output logic       pm
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

`ifdef CLOCK_CTRL_HOUR12_EN
    localparam logic [4:0] HOUR_RST = 5'd12;
`else
    localparam logic [4:0] HOUR_RST = 5'd0;
`endif

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    mode_t            state;
    logic             mode_prev;
    logic             inc_prev;
    logic [CNT_W-1:0] blink_cnt;

    logic mode_edge;
    logic inc_edge;
    logic run_adv;
    logic sec_wrap;
    logic min_wrap;

    assign mode_edge = btn_mode & ~mode_prev;
    assign inc_edge  = btn_inc & ~inc_prev;
    assign sec_wrap  = (second == 6'd59);
    assign min_wrap  = (minute == 6'd59);
    // A mode edge wins over a same-cycle tick, so time only advances when no edge is seen.
    assign run_adv   = (state == RUN) && tick_1hz && !mode_edge;

    assign mode = state;

    function automatic logic [4:0] hour_next(input logic [4:0] h);
`ifdef CLOCK_CTRL_HOUR12_EN
        return (h == 5'd12) ? 5'd1 : h + 5'd1;
`else
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
`endif
    endfunction

    function automatic logic [5:0] min_next(input logic [5:0] m);
        return (m == 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state     <= RUN;
            hour      <= HOUR_RST;
            minute    <= 6'd0;
            second    <= 6'd0;
            blink     <= 1'b0;
            blink_cnt <= '0;
            mode_prev <= 1'b1;
            inc_prev  <= 1'b1;
        end else begin
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
            if (mode_edge) begin
                blink     <= 1'b0;
                blink_cnt <= '0;
                case (state)
                    RUN: begin
                        state  <= SET_HOUR;
                        second <= 6'd0;
                    end
                    SET_HOUR: state <= SET_MIN;
                    default:  state <= RUN;
                endcase
            end else begin
                case (state)
                    RUN: begin
                        blink     <= 1'b0;
                        blink_cnt <= '0;
                        if (tick_1hz) begin
                            second <= min_next(second);
                            if (sec_wrap) begin
                                minute <= min_next(minute);
                                if (min_wrap)
                                    hour <= hour_next(hour);
                            end
                        end
                    end
                    SET_HOUR, SET_MIN: begin
                        if (blink_cnt == CNT_LAST) begin
                            blink_cnt <= '0;
                            blink     <= ~blink;
                        end else begin
                            blink_cnt <= blink_cnt + CNT_W'(1);
                        end
                        if (inc_edge) begin
                            if (state == SET_HOUR)
                                hour <= hour_next(hour);
                            else
                                minute <= min_next(minute);
                        end
                    end
                    default: begin
                        state     <= RUN;
                        blink     <= 1'b0;
                        blink_cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef CLOCK_CTRL_HOUR12_EN
    logic pm_r;

    // pm flips only on the 11:59:59 -> 12:00:00 rollover; set-mode edits never touch it.
    always_ff @(posedge clk_100M) begin
        if (rst)
            pm_r <= 1'b0;
        else if (run_adv && sec_wrap && min_wrap && hour == 5'd11)
            pm_r <= ~pm_r;
    end

    assign pm = pm_r;
`else
    logic unused_run_adv;
    assign unused_run_adv = run_adv;
    assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - table-driven and sequence bench for clock_ctrl (24-hour build, BLINK_DIV=4)
module tb_clock_ctrl;

    logic       clk_100M = 1'b0;
    logic       rst      = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] mode;
    logic       blink;
    logic       pm;

    int vectors = 0;
    int errors  = 0;

    clock_ctrl #(.BLINK_DIV(4)) dut (
        .clk_100M (clk_100M),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hour     (hour),
        .minute   (minute),
        .second   (second),
        .mode     (mode),
        .blink    (blink),
        .pm       (pm)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct {
        logic       rst;
        logic       tick;
        logic       bm;
        logic       bi;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] md;
        logic       chk_blink;
        logic       bl;
    } vec_t;

    vec_t  exp_q[$];
    string name_q[$];
    vec_t  tbl[6];

    function automatic vec_t mk(input logic r, input logic t, input logic bm, input logic bi,
                                input int h, input int m, input int s, input int md,
                                input logic cb, input logic bl);
        vec_t v;
        v.rst = r; v.tick = t; v.bm = bm; v.bi = bi;
        v.h = 5'(h); v.m = 6'(m); v.s = 6'(s); v.md = 2'(md);
        v.chk_blink = cb; v.bl = bl;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        vec_t  e;
        string n;
        rst      = v.rst;
        tick_1hz = v.tick;
        btn_mode = v.bm;
        btn_inc  = v.bi;
        exp_q.push_back(v);
        name_q.push_back(name);
        @(posedge clk_100M);
        #1;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        vectors++;
        if (hour !== e.h || minute !== e.m || second !== e.s || mode !== e.md ||
            pm !== 1'b0 || (e.chk_blink && blink !== e.bl)) begin
            errors++;
            $display("FAIL %s: got h=%0d m=%0d s=%0d mode=%0d blink=%0b pm=%0b, want h=%0d m=%0d s=%0d mode=%0d blink=%0b%s pm=0",
                     n, hour, minute, second, mode, blink, pm, e.h, e.m, e.s, e.md, e.bl,
                     e.chk_blink ? "" : "(dc)");
        end
    endtask

    initial begin
        int eh, em, es;

        tbl[0] = mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[1] = mk(1, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        tbl[2] = mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[4] = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        tbl[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++)
            apply(tbl[i], $sformatf("table%0d", i));

        eh = 0; em = 0; es = 0;
        for (int i = 1; i <= 97; i++) begin
            es++;
            if (es == 60) begin es = 0; em++; end
            apply(mk(0, 1, 0, 0, eh, em, es, 0, 1, 0), (i == 61) ? "tick61" : "tick_run");
        end

        apply(mk(0, 1, 1, 0, eh, em, 0, 1, 1, 0), "run_to_set_hour");
        es = 0;
        for (int i = 1; i <= 25; i++) begin
            eh = (eh + 1) % 24;
            apply(mk(0, 1, 0, 1, eh, em, es, 1, 0, 0), "set_hour_inc");
            apply(mk(0, 1, 0, 0, eh, em, es, 1, 0, 0), "set_hour_release");
        end

        apply(mk(0, 0, 1, 1, eh, em, es, 2, 1, 0), "mode_and_inc");
        for (int k = 1; k <= 20; k++)
            apply(mk(0, 0, 0, 0, eh, em, es, 2, 1, logic'((k / 4) % 2)), "blink_set_min");

        for (int i = 1; i <= 118; i++) begin
            em = (em + 1) % 60;
            apply(mk(0, 0, 0, 1, eh, em, es, 2, 0, 0), "set_min_inc");
            apply(mk(0, 0, 0, 0, eh, em, es, 2, 0, 0), "set_min_release");
        end

        apply(mk(0, 1, 1, 0, eh, em, es, 0, 1, 0), "set_min_to_run");
        apply(mk(0, 0, 0, 0, eh, em, es, 0, 1, 0), "run_blink_low");

        apply(mk(0, 0, 1, 0, eh, em, 0, 1, 1, 0), "to_set_hour2");
        apply(mk(0, 0, 0, 0, eh, em, 0, 1, 1, 0), "release2");
        while (eh != 23) begin
            eh++;
            apply(mk(0, 0, 0, 1, eh, em, 0, 1, 0, 0), "set_hour_to_23");
            apply(mk(0, 0, 0, 0, eh, em, 0, 1, 0, 0), "set_hour_release2");
        end
        apply(mk(0, 0, 1, 0, eh, em, 0, 2, 1, 0), "to_set_min2");
        apply(mk(0, 0, 0, 0, eh, em, 0, 2, 1, 0), "release3");
        apply(mk(0, 0, 1, 0, eh, em, 0, 0, 1, 0), "to_run2");
        apply(mk(0, 0, 0, 0, eh, em, 0, 0, 1, 0), "release4");
        for (int i = 1; i <= 59; i++)
            apply(mk(0, 1, 0, 0, 23, 59, i, 0, 1, 0), "tick_to_235959");
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0), "midnight_wrap");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "after_wrap");

        apply(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0), "to_set_hour3");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "release5");
        apply(mk(0, 0, 1, 0, 0, 0, 0, 2, 1, 0), "to_set_min3");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0), "release6");
        apply(mk(0, 0, 0, 1, 0, 1, 0, 2, 0, 0), "set_min_inc3");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 2, 0, 0), "release7");
        apply(mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0), "rst_in_set_min");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0), "inc_held_over_rst");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "idle_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 SHALL have parameter: BLINK_DIV, default 50000000, clk_100M cycles per blink half-period in set modes.
REQ-002 SHALL have port: clk_100M  input  1  sole clock, 100 MHz.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: tick_1hz  input  1  one-cycle enable pulse, once per second, synchronous to clk_100M.
REQ-005 SHALL have port: btn_mode  input  1  debounced level, mode-advance button.
REQ-006 SHALL have port: btn_inc  input  1  debounced level, field-increment button.
REQ-007 SHALL have port: hour  output  5  current hour, binary.
REQ-008 SHALL have port: minute  output  6  current minute, binary 0..59.
REQ-009 SHALL have port: second  output  6  current second, binary 0..59.
REQ-010 SHALL have port: mode  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN.
REQ-011 SHALL have port: blink  output  1  display-blank strobe for the field being set.
REQ-012 SHALL have port: pm  output  1  afternoon flag (12-hour build only).

Function
REQ-013 SHALL be single-clock: every register clocked on posedge clk_100M; no derived clocks, tick_1hz used as enable only.
REQ-014 SHALL detect btn_mode/btn_inc rising edges with one previous-value register each; an edge event lasts one cycle.
REQ-015 SHALL run mode FSM RUN->SET_HOUR->SET_MIN->RUN, one transition per btn_mode edge; encoding 3 is unreachable and SHALL return to RUN next cycle.
REQ-016 SHALL in RUN, on tick_1hz, advance time one cycle later: second 59->0 carries to minute, minute 59->0 carries to hour, 23:59:59 -> 00:00:00.
REQ-017 SHALL ignore tick_1hz in SET_HOUR and SET_MIN.
REQ-018 SHALL clear second to 0 on the RUN->SET_HOUR transition.
REQ-019 SHALL on btn_inc edge increment hour in SET_HOUR (23->0) or minute in SET_MIN (59->0), no carry to other fields; btn_inc ignored in RUN.
REQ-020 SHALL give btn_mode edge priority: same-cycle btn_inc edge or tick_1hz is discarded.
REQ-021 SHALL in set modes toggle blink every BLINK_DIV cycles, counter restarting with blink=0 on each mode change; blink SHALL be 0 in RUN.
REQ-022 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-023 SHALL on rst=1 at a clock edge set hour=0, minute=0, second=0, mode=0, blink=0, pm=0, blink counter=0.
REQ-024 SHALL load both button previous-value registers with 1 during reset, so a button held through reset release generates no edge.
REQ-025 SHALL let rst override all other inputs, including mid-set-mode and same-cycle tick_1hz.

Configuration
REQ-026 SHALL with macro CLOCK_CTRL_HOUR12_EN defined count hour 1..12: 11:59:59->12:00:00 toggles pm, 12:59:59->01:00:00 keeps pm; set-mode inc 12->1 leaves pm unchanged; reset value hour=12, pm=0.
REQ-027 SHALL without CLOCK_CTRL_HOUR12_EN count hour 0..23 per REQ-016 with pm tied to 0.

Verification
REQ-028 SHALL cover: reset, then 61 tick_1hz pulses in RUN -> hour=0, minute=1, second=1.
REQ-029 SHALL cover: preload 23:59:59, one tick -> 00:00:00 on next cycle (12h build: 11:59:59 pm=0 -> 12:00:00 pm=1).
REQ-030 SHALL cover: btn_mode edge with second=37 -> mode=1, second=0; 25 btn_inc edges -> hour=1 (from 0), minute unchanged; ticks ignored.
REQ-031 SHALL cover: btn_mode and btn_inc edges in same cycle in SET_HOUR -> mode=2, hour unchanged.
REQ-032 SHALL cover: BLINK_DIV=4, SET_MIN held 20 cycles -> blink period 8 cycles; return to RUN -> blink=0.
REQ-033 SHALL cover: btn_mode held high across rst release -> mode stays 0; rst asserted in SET_MIN -> all outputs at reset values next cycle.
